// File: rtl/hilo_unit_if.sv
// hilo_unit_if: op/read bus between the core (master) and the HI/LO unit (slave).
interface hilo_unit_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [63:0] product;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic        dz;
  modport master (output op_valid, op, product, rs_val, rt_val, rd_req, rd_sel,
                  input rd_data, busy, stall, dz);
  modport slave (input op_valid, op, product, rs_val, rt_val, rd_req, rd_sel,
                 output rd_data, busy, stall, dz);
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO registers for MULT/MTHI/MTLO/MFHI/MFLO; iterative DIV/DIVU engine when HILO_DIV_EN is defined.
module hilo_unit (
  input logic clk,
  input logic reset,
  hilo_unit_if.slave bus
);
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic busy, acc;
  assign acc = bus.op_valid & ~busy;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
  assign bus.busy = busy;
  assign bus.stall = busy & (bus.op_valid | bus.rd_req);
`ifdef HILO_DIV_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_mag, b_mag, sub;
  logic sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, sgn, ge;
  logic [32:0] shr;
  assign busy = state_q != IDLE;
  assign bus.dz = dz_q;
  assign sgn = ~bus.op[0];
  assign a_mag = (sgn & bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
  assign b_mag = (sgn & bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
  // remainder is always below the divisor, so the shifted value minus divisor fits in 32 bits
  assign shr = {rem_q, quo_q[31]};
  assign ge = shr >= {1'b0, dvs_q};
  assign sub = shr[31:0] - dvs_q;
`else
  logic unused_ok;
  assign busy = 1'b0;
  assign bus.dz = 1'b0;
  assign unused_ok = ^bus.rt_val;
`endif
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (acc && bus.op == 3'b001) {hi_d, lo_d} = bus.product;
    if (acc && bus.op == 3'b010) hi_d = bus.rs_val;
    if (acc && bus.op == 3'b011) lo_d = bus.rs_val;
`ifdef HILO_DIV_EN
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    sq_d = sq_q;
    sr_d = sr_q;
    dz_d = 1'b0;
    if (acc && bus.op[2:1] == 2'b10) begin
      if (bus.rt_val == '0) begin
        hi_d = bus.rs_val;
        lo_d = '1;
        dz_d = 1'b1;
      end else begin
        state_d = RUN;
        cnt_d = 5'd31;
        rem_d = '0;
        quo_d = a_mag;
        dvs_d = b_mag;
        sq_d = sgn & (bus.rs_val[31] ^ bus.rt_val[31]);
        sr_d = sgn & bus.rs_val[31];
      end
    end
    if (state_q == RUN) begin
      rem_d = ge ? sub : shr[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q - 5'd1;
      state_d = cnt_q == 5'd0 ? FIX : RUN;
    end
    if (state_q == FIX) begin
      lo_d = sq_q ? -quo_q : quo_q;
      hi_d = sr_q ? -rem_q : rem_q;
      state_d = IDLE;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
`ifdef HILO_DIV_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      dz_q <= dz_d;
    end
`endif
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: table vectors, hand-written divide/reset sequences and random ops checked against an arithmetic model.
module tb_hilo_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  hilo_unit_if bus();
  hilo_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [31:0] NH = 32'h12345678, NL = 32'h9ABCDEF0;
  int checks = 0, failures = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo, d;
  int m_cnt;
  logic m_dz;
  typedef struct {
    logic [2:0] op;
    logic [63:0] product;
    logic [31:0] rs, rt, hi, lo;
    logic dz;
  } vec_t;
  vec_t v[14];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    lq = sa / sb;
    lr = sa % sb;
    q = lq[31:0];
    r = lr[31:0];
  endfunction

  function automatic void model_edge();
    m_dz = 1'b0;
    if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.op_valid) begin
      case (bus.op)
        3'd1: {m_hi, m_lo} = bus.product;
        3'd2: m_hi = bus.rs_val;
        3'd3: m_lo = bus.rs_val;
        3'd4, 3'd5: if (DIV_EN) begin
          if (bus.rt_val == 32'd0) begin
            m_hi = bus.rs_val;
            m_lo = 32'hFFFFFFFF;
            m_dz = 1'b1;
          end else begin
            div_ref(bus.op == 3'd4, bus.rs_val, bus.rt_val, p_lo, p_hi);
            m_cnt = 33;
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd(input logic sel, output logic [31:0] data);
    bus.rd_sel = sel;
    #1;
    data = bus.rd_data;
  endtask

  task automatic check_all(string tag);
    logic s;
    logic [31:0] x;
    s = bus.rd_sel;
    chk({tag, "_busy"}, bus.busy, m_cnt != 0);
    chk({tag, "_stall"}, bus.stall, (m_cnt != 0) && (bus.op_valid || bus.rd_req));
    chk({tag, "_dz"}, bus.dz, m_dz);
    rd(1'b1, x);
    chk({tag, "_hi"}, x, m_hi);
    rd(1'b0, x);
    chk({tag, "_lo"}, x, m_lo);
    bus.rd_sel = s;
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] prod, input logic [31:0] rs, input logic [31:0] rt);
    bus.op_valid = 1'b1;
    bus.op = op;
    bus.product = prod;
    bus.rs_val = rs;
    bus.rt_val = rt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    v[0]  = '{3'd1, 64'hFFFFFFFF_FFFFFFF1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    v[1]  = '{3'd2, 64'd0, NH, 32'd0, NH, 32'hFFFFFFF1, 1'b0};
    v[2]  = '{3'd3, 64'd0, NL, 32'd0, NH, NL, 1'b0};
    v[3]  = '{3'd5, 64'd0, 32'd100, 32'd7, DIV_EN ? 32'd2 : NH, DIV_EN ? 32'd14 : NL, 1'b0};
    v[4]  = '{3'd4, 64'd0, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFF : NH, DIV_EN ? 32'hFFFFFFFD : NL, 1'b0};
    v[5]  = '{3'd4, 64'd0, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'd0 : NH, DIV_EN ? 32'h80000000 : NL, 1'b0};
    v[6]  = '{3'd5, 64'd0, 32'hDEAD, 32'd0, DIV_EN ? 32'hDEAD : NH, DIV_EN ? 32'hFFFFFFFF : NL, DIV_EN};
    v[7]  = '{3'd6, 64'd1, 32'd77, 32'd3, DIV_EN ? 32'hDEAD : NH, DIV_EN ? 32'hFFFFFFFF : NL, 1'b0};
    v[8]  = '{3'd0, 64'd2, 32'd78, 32'd3, DIV_EN ? 32'hDEAD : NH, DIV_EN ? 32'hFFFFFFFF : NL, 1'b0};
    v[9]  = '{3'd4, 64'd0, 32'd5, 32'd0, DIV_EN ? 32'd5 : NH, DIV_EN ? 32'hFFFFFFFF : NL, DIV_EN};
    v[10] = '{3'd5, 64'd0, 32'hFFFFFFFF, 32'd16, DIV_EN ? 32'd15 : NH, DIV_EN ? 32'h0FFFFFFF : NL, 1'b0};
    v[11] = '{3'd4, 64'd0, 32'd7, 32'hFFFFFFFE, DIV_EN ? 32'd1 : NH, DIV_EN ? 32'hFFFFFFFD : NL, 1'b0};
    v[12] = '{3'd7, 64'd3, 32'd9, 32'd1, DIV_EN ? 32'd1 : NH, DIV_EN ? 32'hFFFFFFFD : NL, 1'b0};
    v[13] = '{3'd1, 64'h0000000A_0000000B, 32'd0, 32'd0, 32'h0000000A, 32'h0000000B, 1'b0};
    bus.op_valid = 1'b0;
    bus.op = 3'd0;
    bus.product = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_cnt = 0;
    m_dz = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.rd_req = 1'b1;
    check_all("reset");
    bus.rd_req = 1'b0;

    issue(3'd2, 64'd0, NH, 32'd0);
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    #1 chk("mfhi_during_mthi", bus.rd_data, 32'd0);
    tick();
    bus.op_valid = 1'b0;
    bus.rd_req = 1'b0;
    rd(1'b1, d);
    chk("mthi_hi", d, NH);
    rd(1'b0, d);
    chk("mthi_lo_kept", d, 32'd0);

    foreach (v[i]) begin
      issue(v[i].op, v[i].product, v[i].rs, v[i].rt);
      tick();
      bus.op_valid = 1'b0;
      chk($sformatf("vec%0d_dz", i), bus.dz, v[i].dz);
      n = 0;
      while (bus.busy && n < 60) begin
        tick();
        n++;
      end
      chk($sformatf("vec%0d_done", i), bus.busy, 1'b0);
      rd(1'b1, d);
      chk($sformatf("vec%0d_hi", i), d, v[i].hi);
      rd(1'b0, d);
      chk($sformatf("vec%0d_lo", i), d, v[i].lo);
    end

    issue(3'd5, 64'd0, 32'd100, 32'd7);
    tick();
    bus.op_valid = 1'b0;
    n = 0;
    while (bus.busy && n < 60) begin
      n++;
      if (n == 5) begin
        issue(3'd4, 64'd0, 32'd1, 32'd1);
        #1 chk("stall_cycle5", bus.stall, 1'b1);
      end
      tick();
      bus.op_valid = 1'b0;
    end
    chk("busy_cycles", n, DIV_EN ? 32'd33 : 32'd0);
    rd(1'b1, d);
    chk("divu_hi", d, DIV_EN ? 32'd2 : 32'hA);
    rd(1'b0, d);
    chk("divu_lo", d, DIV_EN ? 32'd14 : 32'hB);

    issue(3'd1, 64'h11112222_33334444, 32'd0, 32'd0);
    tick();
    issue(3'd5, 64'd0, 32'd1000, 32'd3);
    tick();
    bus.op_valid = 1'b0;
    repeat (9) tick();
    chk("pre_reset_busy", bus.busy, DIV_EN);
    #1 reset = 1'b1;
    bus.rd_req = 1'b1;
    #1 chk("rst_busy", bus.busy, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    rd(1'b1, d);
    chk("rst_hi", d, 32'd0);
    rd(1'b0, d);
    chk("rst_lo", d, 32'd0);
    m_hi = '0;
    m_lo = '0;
    m_cnt = 0;
    m_dz = 1'b0;
    reset = 1'b0;
    bus.rd_req = 1'b0;
    issue(3'd1, 64'h00000003_FFFFFFF6, 32'd0, 32'd0);
    tick();
    bus.op_valid = 1'b0;
    check_all("post_rst_mult");
    rd(1'b1, d);
    chk("post_rst_hi", d, 32'h3);

    for (int c = 0; c < 800; c++) begin
      bus.op_valid = $urandom_range(0, 2) == 0;
      bus.op = 3'($urandom_range(0, 7));
      bus.product = {$urandom, $urandom};
      bus.rs_val = $urandom;
      case ($urandom_range(0, 7))
        0: bus.rt_val = 32'd0;
        1: bus.rt_val = 32'($urandom_range(1, 15));
        2: begin
          bus.rs_val = 32'h80000000;
          bus.rt_val = 32'hFFFFFFFF;
        end
        default: bus.rt_val = $urandom;
      endcase
      bus.rd_req = 1'($urandom_range(0, 1));
      bus.rd_sel = 1'($urandom_range(0, 1));
      check_all("rnd");
      tick();
    end
    bus.op_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
